// File: rtl/audio_pkg.sv
// Shared types and constants for the audio frame controller slice.
package audio_pkg;

    localparam int AUDIO_SAMPLE_BITS = 24;
    localparam int FRAME_BITS        = 2 * AUDIO_SAMPLE_BITS;

    typedef logic signed [AUDIO_SAMPLE_BITS-1:0] audio_sample_t;

    typedef struct packed {
        audio_sample_t l;
        audio_sample_t r;
    } stereo_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } frame_state_e;

endpackage

// File: rtl/audio_shift_reg.sv
// Parallel-load / serial-shift register with a saturating bit counter.
// Serves as the DAC serializer (PISO) and the ADC deserializer (SIPO).
module audio_shift_reg #(
    parameter int WIDTH = 48,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             shift_in,
    input  logic             clear_cnt,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    // Load beats shift; clear_cnt together with shift counts the new bit as the first one.
    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= load_data;
            count <= '0;
        end else if (shift) begin
            data <= {data[WIDTH-2:0], shift_in};
            if (clear_cnt) begin
                count <= CNT_W'(1);
            end else if (count != CNT_W'(WIDTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (clear_cnt) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/audio_frame_ctrl.sv
// Frame sequencer: prefetches stereo pairs, serializes them onto DOUT and deserializes DIN.
// Optional AUDIO_FRAME_CTRL_REPEAT_LAST_EN replays the last pair on underrun instead of silence.
module audio_frame_ctrl
    import audio_pkg::*;
#(
    parameter int SAMPLE_BITS       = AUDIO_SAMPLE_BITS,
    parameter int UNDERRUN_CNT_BITS = 16
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         ENABLE,
    input  logic                         LOAD,
    input  logic                         OUT_SHIFT,
    input  logic                         IN_SHIFT,
    input  logic                         DIN,
    output logic                         DOUT,
    input  logic [SAMPLE_BITS-1:0]       OUT_L,
    input  logic [SAMPLE_BITS-1:0]       OUT_R,
    input  logic                         OUT_VALID,
    output logic                         OUT_READY,
    output logic [SAMPLE_BITS-1:0]       IN_L,
    output logic [SAMPLE_BITS-1:0]       IN_R,
    output logic                         IN_VALID,
    output logic                         RUNNING,
    output logic [UNDERRUN_CNT_BITS-1:0] UNDERRUN_CNT,
    output logic                         FRAME_ERR
);

    localparam int FRAME_W = 2 * SAMPLE_BITS;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SYNC = SYNC;
    localparam logic [1:0] ST_RUN  = RUN;

    logic [1:0]         state;
    logic               active;
    logic               load_evt;
    logic               stop_evt;
    logic               accept;
    logic               underrun;
    logic               out_shift_en;
    logic               in_shift_en;
    logic               in_complete;
    logic               buf_full;
    logic [FRAME_W-1:0] buf_pair;
    logic [FRAME_W-1:0] out_load_data;
    logic [FRAME_W-1:0] underrun_fill;
    logic [FRAME_W-1:0] out_data;
    logic [FRAME_W-1:0] in_data;
    logic [FRAME_W-1:0] in_next;
    logic [CNT_W-1:0]   out_cnt;
    logic [CNT_W-1:0]   in_cnt;
    logic [FRAME_W-1:0] unused_bits;

    assign active    = (state == ST_SYNC) || (state == ST_RUN);
    assign OUT_READY = active && !buf_full;
    assign accept    = OUT_VALID && OUT_READY;
    assign load_evt  = LOAD && ENABLE && active;
    assign stop_evt  = LOAD && !ENABLE && (state == ST_RUN);
    assign RUNNING   = (state == ST_RUN);
    assign DOUT      = out_data[FRAME_W-1];

    assign out_shift_en = OUT_SHIFT && (state == ST_RUN) && (out_cnt != CNT_W'(FRAME_W));
    assign in_shift_en  = IN_SHIFT && (load_evt || ((state == ST_RUN) && !stop_evt));
    assign in_complete  = in_shift_en && !load_evt && (in_cnt == CNT_W'(FRAME_W - 1));
    assign in_next      = {in_data[FRAME_W-2:0], DIN};
    assign unused_bits  = {out_data[FRAME_W-2:0], in_data[FRAME_W-1]};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (ENABLE) state <= ST_SYNC;
                ST_SYNC: begin
                    if (!ENABLE) begin
                        state <= ST_IDLE;
                    end else if (LOAD) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN:  if (stop_evt) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Frame source priority: buffered pair, then a pair handed over in the LOAD cycle, then underrun fill.
    always_comb begin
        underrun      = 1'b0;
        out_load_data = '0;
        if (load_evt) begin
            if (buf_full) begin
                out_load_data = buf_pair;
            end else if (accept) begin
                out_load_data = {OUT_L, OUT_R};
            end else begin
                underrun      = 1'b1;
                out_load_data = underrun_fill;
            end
        end
    end

`ifdef AUDIO_FRAME_CTRL_REPEAT_LAST_EN
    logic [FRAME_W-1:0] last_pair;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            last_pair <= '0;
        end else if (load_evt && !underrun) begin
            last_pair <= out_load_data;
        end
    end

    assign underrun_fill = last_pair;
`else
    assign underrun_fill = '0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            buf_full <= 1'b0;
            buf_pair <= '0;
        end else if (load_evt && buf_full) begin
            buf_full <= 1'b0;
        end else if (accept && !load_evt) begin
            buf_full <= 1'b1;
            buf_pair <= {OUT_L, OUT_R};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            UNDERRUN_CNT <= '0;
            FRAME_ERR    <= 1'b0;
        end else begin
            if (underrun && (UNDERRUN_CNT != {UNDERRUN_CNT_BITS{1'b1}})) begin
                UNDERRUN_CNT <= UNDERRUN_CNT + UNDERRUN_CNT_BITS'(1);
            end
            if (load_evt && (in_cnt != '0)) begin
                FRAME_ERR <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            IN_L     <= '0;
            IN_R     <= '0;
            IN_VALID <= 1'b0;
        end else begin
            IN_VALID <= in_complete;
            if (in_complete) begin
                IN_L <= in_next[FRAME_W-1:SAMPLE_BITS];
                IN_R <= in_next[SAMPLE_BITS-1:0];
            end
        end
    end

    // A stop LOAD reloads zeros so DOUT idles low.
    audio_shift_reg #(
        .WIDTH(FRAME_W),
        .CNT_W(CNT_W)
    ) u_out_sr (
        .clk      (CLK),
        .reset    (RESET),
        .load     (load_evt || stop_evt),
        .load_data(out_load_data),
        .shift    (out_shift_en),
        .shift_in (1'b0),
        .clear_cnt(1'b0),
        .data     (out_data),
        .count    (out_cnt)
    );

    audio_shift_reg #(
        .WIDTH(FRAME_W),
        .CNT_W(CNT_W)
    ) u_in_sr (
        .clk      (CLK),
        .reset    (RESET),
        .load     (in_complete),
        .load_data(in_next),
        .shift    (in_shift_en),
        .shift_in (DIN),
        .clear_cnt(load_evt || stop_evt),
        .data     (in_data),
        .count    (in_cnt)
    );

endmodule
